// File: rtl/adam_periph_uart_pkg.sv
// Shared types for the UART peripheral: tx FSM states and the frame configuration
// that both the transmitter and the receiver latch at the start of a frame.
`timescale 1ns/1ps
package adam_periph_uart_pkg;

  // Width of the baud_rate field inside the shared config struct.
  localparam int unsigned UART_BAUD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    PAUSED = 3'd5
  } uart_tx_state_t;

  typedef struct packed {
    logic                   parity_select;  // 0 = even, 1 = odd
    logic                   parity_control; // 1 = parity bit present
    logic [3:0]             data_length;    // data bits per frame
    logic [1:0]             stop_bits;      // frame carries stop_bits+1 stop bits
    logic [UART_BAUD_W-1:0] baud_rate;      // clk cycles per bit, 0 and 1 mean 1
  } uart_cfg_t;

  // Reload value for the bit-time down-counter: max(baud,1)-1.
  function automatic logic [UART_BAUD_W-1:0] baud_reload(input logic [UART_BAUD_W-1:0] baud);
    return (baud <= UART_BAUD_W'(1)) ? '0 : (baud - UART_BAUD_W'(1));
  endfunction

endpackage

// File: rtl/adam_periph_uart_baud_tick.sv
// Loadable bit-time down-counter. tick_o is high while the count sits at zero,
// which is the last cycle of the current bit. A load restarts the bit.
`timescale 1ns/1ps
module adam_periph_uart_baud_tick #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/adam_periph_uart_tx.sv
// UART transmitter. Takes words from a valid/ready stream and shifts them out
// LSB first as START, data, optional parity, and one to four STOP bits.
// Handshake: a word is transferred on a rising clk edge where data_valid and
// data_ready are both high; data_ready never depends on data_valid, and the
// source must hold data and the frame config stable until that edge.
// A pause request is honoured only on a frame boundary; while paused the line
// idles high and no words are accepted.
`timescale 1ns/1ps
module adam_periph_uart_tx
  import adam_periph_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  parity_select,
  input  logic                  parity_control,
  input  logic [3:0]            data_length,
  input  logic [1:0]            stop_bits,
  input  logic [DATA_WIDTH-1:0] baud_rate,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output uart_tx_state_t        dbg_state_o
);

  uart_tx_state_t        state_q, state_d;
  uart_cfg_t             cfg_q, cfg_d, cfg_in;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d, par_calc;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [1:0]            stop_idx_q, stop_idx_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  accept;
  logic                  tick;
  logic                  load;
  logic                  go_tail;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  unused_test;

  // DFT mode has no functional effect here.
  assign unused_test = test;

  assign data_ready  = ready_q & ~pause_req;
  assign accept      = data_valid & data_ready;
  assign tx          = tx_q;
  assign pause_ack   = ack_q;
  assign dbg_state_o = state_q;

  // Pack the live config inputs; lengths beyond the data word are clamped.
  always_comb begin
    cfg_in.parity_select  = parity_select;
    cfg_in.parity_control = parity_control;
    cfg_in.data_length    = data_length;
    if (32'(data_length) > DATA_WIDTH) begin
      cfg_in.data_length = 4'(DATA_WIDTH);
    end
    cfg_in.stop_bits      = stop_bits;
    cfg_in.baud_rate      = UART_BAUD_W'(baud_rate);
  end

  // Parity over the data bits that will actually be sent.
  always_comb begin
    par_calc = parity_select;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(cfg_in.data_length)) begin
        par_calc = par_calc ^ data[i];
      end
    end
  end

  // Bit time comes from the live input on accept, otherwise from the latched config.
  always_comb begin
    if (accept) begin
      load_val = DATA_WIDTH'(baud_reload(cfg_in.baud_rate));
    end else begin
      load_val = DATA_WIDTH'(baud_reload(cfg_q.baud_rate));
    end
  end

  adam_periph_uart_baud_tick #(
    .W (DATA_WIDTH)
  ) u_baud_tick (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_o     (tick)
  );

  // Next-state, next-bit and shift logic; every bit change happens on a tick.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    load       = 1'b0;
    go_tail    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pause_req) begin
          state_d = PAUSED;
        end else if (accept) begin
          state_d    = START;
          cfg_d      = cfg_in;
          shift_d    = data;
          par_d      = par_calc;
          bit_idx_d  = '0;
          stop_idx_d = '0;
          tx_d       = 1'b0;
          load       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          load = 1'b1;
          if (cfg_q.data_length == 4'd0) begin
            go_tail = 1'b1;
          end else begin
            state_d   = DATA;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (bit_idx_q == (cfg_q.data_length - 4'd1)) begin
            go_tail = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          load       = 1'b1;
          state_d    = STOP;
          tx_d       = 1'b1;
          stop_idx_d = '0;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_idx_q == cfg_q.stop_bits) begin
            // Frame boundary: a pending pause wins over accepting the next word.
            state_d = pause_req ? PAUSED : IDLE;
          end else begin
            load       = 1'b1;
            stop_idx_d = stop_idx_q + 2'd1;
          end
        end
      end
      PAUSED: begin
        tx_d = 1'b1;
        if (!pause_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // After the last data bit (or straight after START) go to parity or stop.
    if (go_tail) begin
      stop_idx_d = '0;
      if (cfg_q.parity_control) begin
        state_d = PARITY;
        tx_d    = par_q;
      end else begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
    end
  end

  // Ready only in IDLE, and not in the first IDLE cycle after leaving PAUSED.
  always_comb begin
    ready_d = (state_d == IDLE) && (state_q != PAUSED);
    ack_d   = (state_d == PAUSED);
  end

  // State, datapath and registered outputs; reset forces the line idle-high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
    end
  end

endmodule

// File: tb/tb_adam_periph_uart_tx.sv
// Bench for adam_periph_uart_tx: frame-level reference model plus directed and
// randomised traffic, pause and reset scenarios.
`timescale 1ns/1ps
module tb_adam_periph_uart_tx;

  localparam int M_IDLE   = 0;
  localparam int M_FRAME  = 1;
  localparam int M_PAUSED = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        test;
  logic        pause_req;
  logic        pause_ack;
  logic        parity_select;
  logic        parity_control;
  logic [3:0]  data_length;
  logic [1:0]  stop_bits;
  logic [31:0] baud_rate;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        tx;
  adam_periph_uart_pkg::uart_tx_state_t dbg_state;

  always #5 clk = ~clk;

  adam_periph_uart_tx #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .test           (test),
    .pause_req      (pause_req),
    .pause_ack      (pause_ack),
    .parity_select  (parity_select),
    .parity_control (parity_control),
    .data_length    (data_length),
    .stop_bits      (stop_bits),
    .baud_rate      (baud_rate),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .tx             (tx),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int sent    = 0;
  int acc_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Number of bit slots in a frame.
  function automatic int frame_nbits(input int len, input bit pc, input int sb);
    return 1 + len + (pc ? 1 : 0) + sb + 1;
  endfunction

  // Line level of bit slot idx of a frame (0 = start bit).
  function automatic logic frame_bit(input logic [31:0] d, input int len, input bit pc,
                                     input bit ps, input int idx);
    logic p;
    if (idx == 0) return 1'b0;
    if (idx <= len) return d[idx-1];
    if (pc && idx == len + 1) begin
      p = ps;
      for (int i = 0; i < len; i++) p = p ^ d[i];
      return p;
    end
    return 1'b1;
  endfunction

  // Remaining per-cycle line values of the frame in flight.
  logic [0:0] exp_q[$];
  int   mode  = M_IDLE;
  logic m_tx  = 1'b1;
  logic m_rdy = 1'b0;
  logic m_ack = 1'b0;

  // Compare on the falling edge, then advance the model to the next cycle.
  always @(negedge clk) begin
    if (!rst) begin
      mode  = M_IDLE;
      m_tx  = 1'b1;
      m_rdy = 1'b0;
      m_ack = 1'b0;
      exp_q.delete();
    end else begin
      if (chk_en) begin
        check("tx", 32'(tx), 32'(m_tx));
        check("data_ready", 32'(data_ready), 32'(m_rdy && !pause_req));
        check("pause_ack", 32'(pause_ack), 32'(m_ack));
      end
      case (mode)
        M_FRAME: begin
          if (exp_q.size() > 0) begin
            m_tx = exp_q.pop_front();
          end else begin
            m_tx = 1'b1;
            if (pause_req) begin
              mode = M_PAUSED; m_ack = 1'b1; m_rdy = 1'b0;
            end else begin
              mode = M_IDLE; m_rdy = 1'b1;
            end
          end
        end
        M_IDLE: begin
          m_tx = 1'b1;
          if (pause_req) begin
            mode = M_PAUSED; m_ack = 1'b1; m_rdy = 1'b0;
          end else if (data_valid && m_rdy) begin
            int nb;
            int reps;
            nb   = frame_nbits(int'(data_length), parity_control, int'(stop_bits));
            reps = (baud_rate <= 1) ? 1 : int'(baud_rate);
            for (int b = 0; b < nb; b++)
              for (int r = 0; r < reps; r++)
                exp_q.push_back(frame_bit(data, int'(data_length), parity_control,
                                          parity_select, b));
            m_tx  = exp_q.pop_front();
            mode  = M_FRAME;
            m_rdy = 1'b0;
            acc_cnt++;
          end else begin
            m_rdy = 1'b1;
          end
        end
        default: begin
          if (!pause_req) begin
            mode = M_IDLE; m_ack = 1'b0; m_rdy = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word with its frame config and wait (bounded) for the handshake.
  task automatic send(input logic [31:0] w, input int len, input bit pc, input bit ps,
                      input int sb, input logic [31:0] baud, input bit hold);
    bit hs;
    data           = w;
    data_length    = 4'(len);
    parity_control = pc;
    parity_select  = ps;
    stop_bits      = 2'(sb);
    baud_rate      = baud;
    data_valid     = 1'b1;
    hs = 1'b0;
    for (int k = 0; k < 3000 && !hs; k++) begin
      @(negedge clk);
      if (data_ready === 1'b1) hs = 1'b1;
    end
    if (!hs) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout at %0t: got no handshake expected one for %0h", $time, w);
    end else begin
      sent++;
    end
    @(posedge clk);
    #1;
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(posedge clk);
      #1;
      if (mode == M_IDLE && m_rdy) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout at %0t: got busy expected idle", $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] seq_exp;
    logic [11:0] seq_got;

    rst = 1'b0; test = 1'b0; pause_req = 1'b0;
    parity_select = 1'b0; parity_control = 1'b0; data_length = 4'd8;
    stop_bits = 2'd0; baud_rate = 32'd1; data = '0; data_valid = 1'b0;

    // Pin the model against hand-derived frames.
    seq_exp = 12'b1101_0100_1010;
    for (int i = 0; i < 12; i++) seq_got[i] = frame_bit(32'hA5, 8, 1'b1, 1'b0, i);
    check("model_a5_frame", 32'(seq_got), 32'(seq_exp));
    check("model_a5_len", 32'(frame_nbits(8, 1'b1, 1)), 32'd12);
    check("model_1f_parity", 32'(frame_bit(32'h1F, 5, 1'b1, 1'b1, 6)), 32'd0);
    check("model_1f_len", 32'(frame_nbits(5, 1'b1, 0)), 32'd8);

    // Reset values while rst is held low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(data_ready), 32'd0);
    check("rst_ack", 32'(pause_ack), 32'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    wait_cycles(1);
    check("ready_after_rst", 32'(data_ready), 32'd1);

    // 0xA5, 8 bits, even parity, two stop bits, 10 cycles per bit.
    send(32'hA5, 8, 1'b1, 1'b0, 1, 32'd10, 1'b0);
    wait_idle();

    // Single-cycle bits for baud 0 and 1, 5 bits, odd parity.
    send(32'h1F, 5, 1'b1, 1'b1, 0, 32'd0, 1'b0);
    wait_idle();
    send(32'h1F, 5, 1'b1, 1'b1, 0, 32'd1, 1'b0);
    wait_idle();

    // Pause raised during the third data bit.
    send(32'h3C, 8, 1'b1, 1'b0, 0, 32'd4, 1'b0);
    wait_cycles(12);
    pause_req = 1'b1;
    wait_cycles(50);
    check("paused_ack", 32'(pause_ack), 32'd1);
    check("paused_tx", 32'(tx), 32'd1);
    check("paused_ready", 32'(data_ready), 32'd0);
    pause_req = 1'b0;
    wait_cycles(1);
    check("unpause_ack", 32'(pause_ack), 32'd0);
    check("unpause_ready_gap", 32'(data_ready), 32'd0);
    wait_cycles(1);
    check("unpause_ready", 32'(data_ready), 32'd1);

    // Pause requested in IDLE: ready drops in the same cycle.
    pause_req = 1'b1;
    #1;
    check("idle_pause_ready", 32'(data_ready), 32'd0);
    wait_cycles(5);
    pause_req = 1'b0;
    wait_cycles(3);

    // Reset mid-frame, then a clean frame.
    send(32'h5A, 8, 1'b0, 1'b0, 0, 32'd3, 1'b0);
    wait_cycles(10);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(data_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(32'hC3, 8, 1'b1, 1'b1, 1, 32'd2, 1'b0);
    wait_idle();

    // Stream of four words with config changed while each frame is on the line.
    send(32'h11, 8, 1'b0, 1'b0, 0, 32'd3, 1'b1);
    send(32'h2F, 4, 1'b1, 1'b0, 1, 32'd2, 1'b1);
    send(32'h7E, 7, 1'b1, 1'b1, 0, 32'd1, 1'b1);
    send(32'hABCD, 15, 1'b0, 1'b0, 3, 32'd2, 1'b0);
    wait_idle();

    // Randomised frames, gaps and pauses.
    for (int n = 0; n < 30; n++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send($urandom, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3), 32'($urandom_range(0, 4)), hold);
      if (!hold) begin
        wait_cycles($urandom_range(0, 20));
        if ($urandom_range(0, 3) == 0) begin
          pause_req = 1'b1;
          wait_cycles($urandom_range(1, 30));
          pause_req = 1'b0;
        end
      end
    end
    data_valid = 1'b0;
    wait_idle();

    check("accept_count", 32'(acc_cnt), 32'(sent));
    wait_cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
